// File: rtl/input_conditioner_pkg.sv
// Shared sizing constants and debounce state type for the input conditioner.
package input_conditioner_pkg;

    localparam int unsigned SW_SZ_DEF         = 4;
    localparam int unsigned BTN_SZ_DEF        = 4;
    localparam int unsigned DEB_CYCLES_DEF    = 1000000;
    localparam int unsigned HOLD_CYCLES_DEF   = 50000000;
    localparam int unsigned REPEAT_CYCLES_DEF = 20000000;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce FSM, level and rise pulse.
// INPUT_COND_REPEAT_EN adds hold/auto-repeat pulses while the level stays high.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF
`ifdef INPUT_COND_REPEAT_EN
   ,parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_lvl,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_press;
    logic          w_s;
    logic          w_accept_hi;
    logic          w_rep_fire;

    assign w_s         = r_sync2;
    assign w_accept_hi = (r_state == S_WAIT_HI) && w_s && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level is registered alongside the state so it never glitches between states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept_hi | w_rep_fire;
            case (r_state)
                S_LO: begin
                    if (w_s) begin
                        r_state <= S_WAIT_HI;
                        r_cnt   <= CW'(1);
                    end
                end
                S_WAIT_HI: begin
                    if (!w_s) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                        r_lvl   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HI: begin
                    if (!w_s) begin
                        r_state <= S_WAIT_LO;
                        r_cnt   <= CW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (w_s) begin
                        r_state <= S_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_LO;
                        r_cnt   <= '0;
                        r_lvl   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_LO;
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_COND_REPEAT_EN
    localparam int unsigned HW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    logic [HW-1:0] r_hold;
    logic          r_rep;
    logic          w_in_hi;
    logic [HW-1:0] w_hold_last;

    assign w_in_hi     = (r_state == S_HI) && w_s;
    assign w_hold_last = r_rep ? HW'(REPEAT_CYCLES - 1) : HW'(HOLD_CYCLES - 1);
    assign w_rep_fire  = w_in_hi && (r_hold == w_hold_last);

    // First period is HOLD_CYCLES, every later one REPEAT_CYCLES; any exit from S_HI restarts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else if (!w_in_hi) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else if (w_rep_fire) begin
            r_hold <= '0;
            r_rep  <= 1'b1;
        end else begin
            r_hold <= r_hold + HW'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign o_lvl   = r_lvl;
    assign o_press = r_press;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces board switches and buttons; one debounce_bit per pin.
// INPUT_COND_REPEAT_EN enables held-button auto-repeat pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SW_SZ         = SW_SZ_DEF,
    parameter int unsigned BTN_SZ        = BTN_SZ_DEF,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SW_SZ-1:0]  sw_i,
    input  logic [BTN_SZ-1:0] btn_i,
    output logic [SW_SZ-1:0]  sw_o,
    output logic [BTN_SZ-1:0] btn_lvl_o,
    output logic [BTN_SZ-1:0] btn_press_o
);

    // Switches share the button datapath; their pulses are deliberately discarded.
    logic [SW_SZ-1:0] w_sw_press_unused;

`ifndef INPUT_COND_REPEAT_EN
    localparam int unsigned LP_REPEAT_CFG_UNUSED = HOLD_CYCLES + REPEAT_CYCLES;
`endif

    for (genvar gi = 0; gi < SW_SZ; gi++) begin : g_sw
        debounce_bit #(
            .DEB_CYCLES   (DEB_CYCLES)
        ) u_sw (
            .i_clk   (clk_i),
            .i_rst_n (rst_i),
            .i_raw   (sw_i[gi]),
            .o_lvl   (sw_o[gi]),
            .o_press (w_sw_press_unused[gi])
        );
    end

    for (genvar gi = 0; gi < BTN_SZ; gi++) begin : g_btn
        debounce_bit #(
            .DEB_CYCLES   (DEB_CYCLES)
`ifdef INPUT_COND_REPEAT_EN
           ,.HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_btn (
            .i_clk   (clk_i),
            .i_rst_n (rst_i),
            .i_raw   (btn_i[gi]),
            .o_lvl   (btn_lvl_o[gi]),
            .o_press (btn_press_o[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a behavioural run-length model.
module tb_input_conditioner;

    localparam int unsigned SW   = 4;
    localparam int unsigned BTN  = 4;
    localparam int unsigned NB   = SW + BTN;
    localparam int unsigned DEB  = 8;
    localparam int unsigned HOLD = 40;
    localparam int unsigned REP  = 16;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [SW-1:0]  sw_i;
    logic [BTN-1:0] btn_i;
    logic [SW-1:0]  sw_o;
    logic [BTN-1:0] btn_lvl_o;
    logic [BTN-1:0] btn_press_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .SW_SZ        (SW),
        .BTN_SZ       (BTN),
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sw_i        (sw_i),
        .btn_i       (btn_i),
        .sw_o        (sw_o),
        .btn_lvl_o   (btn_lvl_o),
        .btn_press_o (btn_press_o)
    );

    // Reference: a level flips once the synchronised input has disagreed with it
    // for DEB consecutive cycles; any agreeing cycle zeroes the disagreement run.
    logic        m_s1[NB];
    logic        m_s2[NB];
    logic        m_lvl[NB];
    logic        m_press[NB];
    int unsigned m_run[NB];
    int unsigned m_held[NB];
    logic [NB-1:0] w_raw;
    assign w_raw = {btn_i, sw_i};

    function automatic int unsigned f_run(input logic s, input logic lvl, input int unsigned run);
        if (s == lvl) return 0;
        if (run + 1 == DEB) return 0;
        return run + 1;
    endfunction

    function automatic logic f_lvl(input logic s, input logic lvl, input int unsigned run);
        if (s != lvl && run + 1 == DEB) return s;
        return lvl;
    endfunction

    function automatic int unsigned f_held(input logic s, input logic lvl, input int unsigned run,
                                           input int unsigned held);
        return (lvl && run == 0 && s) ? held + 1 : 0;
    endfunction

    function automatic logic f_press(input int idx, input logic s, input logic lvl,
                                     input int unsigned run, input int unsigned held);
`ifdef INPUT_COND_REPEAT_EN
        int unsigned h;
`endif
        if (idx < int'(SW)) return 1'b0;
        if (s && !lvl && run + 1 == DEB) return 1'b1;
`ifdef INPUT_COND_REPEAT_EN
        if (lvl && run == 0 && s) begin
            h = held + 1;
            if (h == HOLD || (h > HOLD && (h - HOLD) % REP == 0)) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(NB); i++) begin
                m_s1[i] <= 1'b0; m_s2[i] <= 1'b0; m_lvl[i] <= 1'b0;
                m_press[i] <= 1'b0; m_run[i] <= 0; m_held[i] <= 0;
            end
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                m_s1[i]    <= w_raw[i];
                m_s2[i]    <= m_s1[i];
                m_lvl[i]   <= f_lvl(m_s2[i], m_lvl[i], m_run[i]);
                m_run[i]   <= f_run(m_s2[i], m_lvl[i], m_run[i]);
                m_held[i]  <= f_held(m_s2[i], m_lvl[i], m_run[i], m_held[i]);
                m_press[i] <= f_press(i, m_s2[i], m_lvl[i], m_run[i], m_held[i]);
            end
        end
    end

    function automatic logic [NB-1:0] f_mlvl();
        logic [NB-1:0] v;
        for (int i = 0; i < int'(NB); i++) v[i] = m_lvl[i];
        return v;
    endfunction

    function automatic logic [BTN-1:0] f_mpress();
        logic [BTN-1:0] v;
        for (int i = 0; i < int'(BTN); i++) v[i] = m_press[SW + i];
        return v;
    endfunction

    task automatic test_reset();
        int unsigned lvl_at, press_at, npress;
        lvl_at = 0; press_at = 0; npress = 0;
        rst_i = 1'b0; btn_i = '1; sw_i = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sw_o, btn_lvl_o, btn_press_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {sw_o, btn_lvl_o, btn_press_o});
        end
        rst_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press_o != 4'h0) begin
                npress++;
                if (press_at == 0 && btn_press_o == 4'hF) press_at = c;
            end
            if (lvl_at == 0 && btn_lvl_o == 4'hF) lvl_at = c;
        end
        n_checks++;
        if (lvl_at < 9 || lvl_at > 11) begin
            n_fail++;
            $display("FAIL reset_release_lvl_latency: got %0d expected 10+-1", lvl_at);
        end
        n_checks++;
        if (press_at != lvl_at || npress != 1) begin
            n_fail++;
            $display("FAIL reset_release_pulse: got cycle %0d count %0d expected cycle %0d count 1",
                     press_at, npress, lvl_at);
        end
        n_checks++;
        if (sw_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_release_sw: got %h expected f", sw_o);
        end
    endtask

    task automatic test_clean_press();
        int unsigned lvl_at, press_at, npress, nother, fall_at, nrel;
        lvl_at = 0; press_at = 0; npress = 0; nother = 0; fall_at = 0; nrel = 0;
        btn_i = '0; sw_i = '0;
        repeat (15) @(negedge clk);
        n_checks++;
        if ({sw_o, btn_lvl_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_levels: got %h expected 00", {sw_o, btn_lvl_o});
        end
        btn_i = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (btn_press_o[0]) begin
                npress++;
                if (press_at == 0) press_at = c;
            end
            if (btn_press_o[3:1] != 3'b000) nother++;
            if (lvl_at == 0 && btn_lvl_o[0]) lvl_at = c;
        end
        n_checks++;
        if (press_at < 9 || press_at > 11 || npress != 1 || nother != 0) begin
            n_fail++;
            $display("FAIL clean_press_pulse: got cycle %0d count %0d others %0d expected 10+-1 1 0",
                     press_at, npress, nother);
        end
        n_checks++;
        if (lvl_at != press_at || btn_lvl_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_press_level: got rise %0d lvl %b expected rise %0d lvl 1",
                     lvl_at, btn_lvl_o[0], press_at);
        end
        btn_i = 4'b0000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (btn_press_o != 4'h0) nrel++;
            if (fall_at == 0 && !btn_lvl_o[0]) fall_at = c;
        end
        n_checks++;
        if (fall_at < 9 || fall_at > 11 || nrel != 0) begin
            n_fail++;
            $display("FAIL clean_release: got fall %0d pulses %0d expected 10+-1 0", fall_at, nrel);
        end
    endtask

    task automatic test_bounce();
        int unsigned npress, nlvl, nstable;
        npress = 0; nlvl = 0; nstable = 0;
        for (int c = 0; c < 100; c++) begin
            btn_i[1] = ((c / 5) % 2 == 0);
            @(negedge clk);
            if (btn_press_o[1]) npress++;
            if (btn_lvl_o[1]) nlvl++;
        end
        n_checks++;
        if (npress != 0 || nlvl != 0) begin
            n_fail++;
            $display("FAIL bounce_rejected: got pulses %0d high_cycles %0d expected 0 0", npress, nlvl);
        end
        btn_i[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (btn_press_o[1]) nstable++;
        end
        n_checks++;
        if (nstable != 1 || btn_lvl_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_then_stable: got pulses %0d lvl %b expected 1 1", nstable, btn_lvl_o[1]);
        end
        btn_i = '0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int unsigned at, nz;
        logic [BTN-1:0] val;
        at = 0; nz = 0; val = '0;
        btn_i = 4'b1010;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (btn_press_o != 4'h0) begin
                nz++;
                if (at == 0) begin
                    at = c; val = btn_press_o;
                end
            end
        end
        n_checks++;
        if (val !== 4'b1010 || nz != 1 || at < 9 || at > 11) begin
            n_fail++;
            $display("FAIL simultaneous: got %b at %0d over %0d cycles expected 1010 at 10+-1 over 1",
                     val, at, nz);
        end
        btn_i = '0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int unsigned npress, lvl_at, sw_at, np_after;
        npress = 0; lvl_at = 0; sw_at = 0; np_after = 0;
        sw_i = '1;
        repeat (15) @(negedge clk);
        btn_i = 4'b0100;
        repeat (7) @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({sw_o, btn_lvl_o, btn_press_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_async_clear: got %h expected 000", {sw_o, btn_lvl_o, btn_press_o});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (btn_press_o != 4'h0 || btn_lvl_o != 4'h0 || sw_o != 4'h0) npress++;
        end
        n_checks++;
        if (npress != 0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %0d active cycles expected 0", npress);
        end
        rst_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lvl_at == 0 && btn_lvl_o[2]) lvl_at = c;
            if (sw_at == 0 && sw_o == 4'hF) sw_at = c;
            if (btn_press_o[2]) np_after++;
        end
        n_checks++;
        if (lvl_at < 9 || lvl_at > 11 || sw_at != lvl_at || np_after != 1) begin
            n_fail++;
            $display("FAIL mid_reset_requalify: got btn %0d sw %0d pulses %0d expected 10+-1 same 1",
                     lvl_at, sw_at, np_after);
        end
        btn_i = '0; sw_i = '0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_repeat();
        int unsigned got[$];
        int unsigned exp[$];
        int unsigned acc;
        acc = 0;
        btn_i = 4'b1000;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (btn_press_o[3]) got.push_back(c);
            if (acc == 0 && btn_lvl_o[3]) acc = c;
        end
        exp.push_back(acc);
`ifdef INPUT_COND_REPEAT_EN
        for (int unsigned t = acc + HOLD; t <= 120; t += REP) exp.push_back(t);
`endif
        n_checks++;
        if (acc < 9 || acc > 11) begin
            n_fail++;
            $display("FAIL repeat_accept: got %0d expected 10+-1", acc);
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            foreach (exp[k]) begin
                n_checks++;
                if (got[k] != exp[k]) begin
                    n_fail++;
                    $display("FAIL repeat_pulse_%0d: got cycle %0d expected %0d", k, got[k], exp[k]);
                end
            end
        end
        btn_i = '0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_random();
        int unsigned left[NB];
        logic [NB-1:0] raw;
        logic [NB-1:0] ml;
        raw = '0;
        for (int i = 0; i < int'(NB); i++) left[i] = $urandom_range(1, 12);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (left[i] == 0) begin
                    raw[i] = ~raw[i];
                    left[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 80) : $urandom_range(1, 12);
                end
                left[i]--;
            end
            {btn_i, sw_i} = raw;
            @(negedge clk);
            ml = f_mlvl();
            n_checks++;
            if (sw_o !== ml[SW-1:0]) begin
                n_fail++;
                $display("FAIL random_sw_o c%0d: got %b expected %b", c, sw_o, ml[SW-1:0]);
            end
            n_checks++;
            if (btn_lvl_o !== ml[NB-1:SW]) begin
                n_fail++;
                $display("FAIL random_btn_lvl c%0d: got %b expected %b", c, btn_lvl_o, ml[NB-1:SW]);
            end
            n_checks++;
            if (btn_press_o !== f_mpress()) begin
                n_fail++;
                $display("FAIL random_btn_press c%0d: got %b expected %b", c, btn_press_o, f_mpress());
            end
        end
        btn_i = '0; sw_i = '0;
        repeat (15) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; sw_i = '0; btn_i = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_mid_reset();
        test_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
